// File: rtl/tcm_arb_pkg.sv
// Shared definitions for the TCM data-port arbiter: owner ids, tag width
// defaults and the request bundle carried from either master to tcm_mem.
package tcm_arb_pkg;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    localparam int ARB_TAG_W     = 11;
    // Widest tag the request bundle can carry; narrower tags are zero-extended.
    localparam int ARB_TAG_MAX_W = 32;

    typedef struct packed {
        logic [31:0]              addr;
        logic [31:0]              data;
        logic                     rd;
        logic [3:0]               wr;
        logic                     cacheable;
        logic [ARB_TAG_MAX_W-1:0] tag;
        logic                     invalidate;
        logic                     writeback;
        logic                     flush;
    } arb_req_t;

    function automatic logic req_active(input arb_req_t r);
        return r.rd | (|r.wr) | r.invalidate | r.writeback | r.flush;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit owner ids, one entry per request accepted downstream
// and not yet acknowledged. Pointers wrap naturally since depth is a power of two.
module arb_owner_fifo #(
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = $clog2(OUTSTANDING),
    parameter int CNT_W       = $clog2(OUTSTANDING) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             push_data_i,
    input  logic             pop_i,
    output logic             head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [OUTSTANDING-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(OUTSTANDING));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for storage, pointers and occupancy; push+pop leaves count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Registers with synchronous reset; reset discards every tracked owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// Round-robin arbiter sharing the TCM data port between the core (port 0)
// and an auxiliary master (port 1). A stalled grant is locked to its owner
// until accepted; responses are steered back using an in-order owner FIFO.
// TAG_W may be at most ARB_TAG_MAX_W.
module tcm_dport_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int TAG_W       = ARB_TAG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      p0_addr_i,
    input  logic [31:0]      p0_data_wr_i,
    input  logic             p0_rd_i,
    input  logic [3:0]       p0_wr_i,
    input  logic             p0_cacheable_i,
    input  logic [TAG_W-1:0] p0_req_tag_i,
    input  logic             p0_invalidate_i,
    input  logic             p0_writeback_i,
    input  logic             p0_flush_i,
    output logic             p0_accept_o,
    output logic             p0_ack_o,
    output logic             p0_error_o,
    output logic [31:0]      p0_data_rd_o,
    output logic [TAG_W-1:0] p0_resp_tag_o,
    input  logic [31:0]      p1_addr_i,
    input  logic [31:0]      p1_data_wr_i,
    input  logic             p1_rd_i,
    input  logic [3:0]       p1_wr_i,
    input  logic [TAG_W-1:0] p1_req_tag_i,
    output logic             p1_accept_o,
    output logic             p1_ack_o,
    output logic             p1_error_o,
    output logic [31:0]      p1_data_rd_o,
    output logic [TAG_W-1:0] p1_resp_tag_o,
    output logic [31:0]      m_addr_o,
    output logic [31:0]      m_data_wr_o,
    output logic             m_rd_o,
    output logic [3:0]       m_wr_o,
    output logic             m_cacheable_o,
    output logic [TAG_W-1:0] m_req_tag_o,
    output logic             m_invalidate_o,
    output logic             m_writeback_o,
    output logic             m_flush_o,
    input  logic             m_accept_i,
    input  logic             m_ack_i,
    input  logic             m_error_i,
    input  logic [31:0]      m_data_rd_i,
    input  logic [TAG_W-1:0] m_resp_tag_i,
    output logic             spurious_o
);

    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    arb_req_t   p0_req, p1_req, m_req;
    logic       p0_act, p1_act;
    logic       gnt_valid, gnt_port;
    logic       accept, ack_valid;
    logic       fifo_full, fifo_empty, fifo_head;
    logic [CNT_W-1:0] unused_fifo_count;
    logic       unused_tag_hi;

    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic       lock_owner_q, lock_owner_d;
    logic       spurious_q, spurious_d;

    // Pack both masters into the common request bundle; port 1 has no maintenance ops.
    always_comb begin
        p0_req            = '0;
        p0_req.addr       = p0_addr_i;
        p0_req.data       = p0_data_wr_i;
        p0_req.rd         = p0_rd_i;
        p0_req.wr         = p0_wr_i;
        p0_req.cacheable  = p0_cacheable_i;
        p0_req.tag        = ARB_TAG_MAX_W'(p0_req_tag_i);
        p0_req.invalidate = p0_invalidate_i;
        p0_req.writeback  = p0_writeback_i;
        p0_req.flush      = p0_flush_i;
        p1_req            = '0;
        p1_req.addr       = p1_addr_i;
        p1_req.data       = p1_data_wr_i;
        p1_req.rd         = p1_rd_i;
        p1_req.wr         = p1_wr_i;
        p1_req.tag        = ARB_TAG_MAX_W'(p1_req_tag_i);
    end

    assign p0_act = req_active(p0_req);
    assign p1_act = req_active(p1_req);

    // Grant: a live lock wins, otherwise round-robin against the last accepted port.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = ARB_P0;
        if (lock_q && ((lock_owner_q == ARB_P0) ? p0_act : p1_act)) begin
            gnt_valid = 1'b1;
            gnt_port  = lock_owner_q;
        end else if (p0_act && p1_act) begin
            gnt_valid = 1'b1;
            gnt_port  = ~last_q;
        end else if (p0_act) begin
            gnt_valid = 1'b1;
            gnt_port  = ARB_P0;
        end else if (p1_act) begin
            gnt_valid = 1'b1;
            gnt_port  = ARB_P1;
        end
    end

    assign accept      = gnt_valid & m_accept_i & ~fifo_full & ~rst_i;
    assign p0_accept_o = accept & (gnt_port == ARB_P0);
    assign p1_accept_o = accept & (gnt_port == ARB_P1);

    // Downstream request mux; reads/writes are suppressed while full or in reset.
    always_comb begin
        m_req = '0;
        if (gnt_valid) begin
            m_req = (gnt_port == ARB_P0) ? p0_req : p1_req;
        end
        if (fifo_full || rst_i) begin
            m_req.rd = 1'b0;
            m_req.wr = 4'b0;
        end
    end

    assign m_addr_o       = m_req.addr;
    assign m_data_wr_o    = m_req.data;
    assign m_rd_o         = m_req.rd;
    assign m_wr_o         = m_req.wr;
    assign m_cacheable_o  = m_req.cacheable;
    assign m_req_tag_o    = m_req.tag[TAG_W-1:0];
    assign m_invalidate_o = m_req.invalidate;
    assign m_writeback_o  = m_req.writeback;
    assign m_flush_o      = m_req.flush;
    assign unused_tag_hi  = ^m_req.tag;

    // Round-robin history, lock tracking and the sticky spurious-ack flag.
    always_comb begin
        last_d       = accept ? gnt_port : last_q;
        lock_d       = gnt_valid & ~accept;
        lock_owner_d = gnt_valid ? gnt_port : lock_owner_q;
        spurious_d   = spurious_q | (m_ack_i & fifo_empty);
    end

    // State registers; after reset port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= ARB_P1;
            lock_q       <= 1'b0;
            lock_owner_q <= ARB_P0;
            spurious_q   <= 1'b0;
        end else begin
            last_q       <= last_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            spurious_q   <= spurious_d;
        end
    end

    assign spurious_o = spurious_q;

    arb_owner_fifo #(
        .OUTSTANDING (OUTSTANDING)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (gnt_port),
        .pop_i       (ack_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (unused_fifo_count)
    );

    assign ack_valid     = m_ack_i & ~fifo_empty & ~rst_i;
    assign p0_ack_o      = ack_valid & (fifo_head == ARB_P0);
    assign p1_ack_o      = ack_valid & (fifo_head == ARB_P1);
    assign p0_error_o    = p0_ack_o & m_error_i;
    assign p1_error_o    = p1_ack_o & m_error_i;
    assign p0_data_rd_o  = m_data_rd_i;
    assign p1_data_rd_o  = m_data_rd_i;
    assign p0_resp_tag_o = m_resp_tag_i;
    assign p1_resp_tag_o = m_resp_tag_i;

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Randomized and directed bench for tcm_dport_arbiter with a transaction-level
// reference model and a response scoreboard drained by a separate monitor.
module tb_tcm_dport_arbiter;

    localparam int OUTSTANDING = 4;
    localparam int TAG_W       = 11;
    localparam int REQ_W       = 73 + TAG_W;

    logic clk = 1'b0;
    logic rst_i;
    logic [31:0] p0_addr_i, p0_data_wr_i, p1_addr_i, p1_data_wr_i;
    logic p0_rd_i, p1_rd_i, p0_cacheable_i, p0_invalidate_i, p0_writeback_i, p0_flush_i;
    logic [3:0] p0_wr_i, p1_wr_i;
    logic [TAG_W-1:0] p0_req_tag_i, p1_req_tag_i;
    logic p0_accept_o, p0_ack_o, p0_error_o, p1_accept_o, p1_ack_o, p1_error_o;
    logic [31:0] p0_data_rd_o, p1_data_rd_o;
    logic [TAG_W-1:0] p0_resp_tag_o, p1_resp_tag_o;
    logic [31:0] m_addr_o, m_data_wr_o;
    logic m_rd_o, m_cacheable_o, m_invalidate_o, m_writeback_o, m_flush_o;
    logic [3:0] m_wr_o;
    logic [TAG_W-1:0] m_req_tag_o;
    logic m_accept_i, m_ack_i, m_error_i;
    logic [31:0] m_data_rd_i;
    logic [TAG_W-1:0] m_resp_tag_i;
    logic spurious_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owners in flight, last winner, port holding a stalled grant.
    int own_q[$];
    int last_m = 1;
    int held_m = -1;
    bit spur_m = 1'b0;
    int acc_port = -1;
    bit pend0 = 1'b0;
    bit pend1 = 1'b0;

    typedef struct {
        logic [1:0]       ack;
        logic [1:0]       err;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } resp_t;
    resp_t sb_q[$];

    always #5 clk = ~clk;

    tcm_dport_arbiter #(.OUTSTANDING(OUTSTANDING), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_addr_i(p0_addr_i), .p0_data_wr_i(p0_data_wr_i), .p0_rd_i(p0_rd_i),
        .p0_wr_i(p0_wr_i), .p0_cacheable_i(p0_cacheable_i), .p0_req_tag_i(p0_req_tag_i),
        .p0_invalidate_i(p0_invalidate_i), .p0_writeback_i(p0_writeback_i), .p0_flush_i(p0_flush_i),
        .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o), .p0_error_o(p0_error_o),
        .p0_data_rd_o(p0_data_rd_o), .p0_resp_tag_o(p0_resp_tag_o),
        .p1_addr_i(p1_addr_i), .p1_data_wr_i(p1_data_wr_i), .p1_rd_i(p1_rd_i),
        .p1_wr_i(p1_wr_i), .p1_req_tag_i(p1_req_tag_i),
        .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o), .p1_error_o(p1_error_o),
        .p1_data_rd_o(p1_data_rd_o), .p1_resp_tag_o(p1_resp_tag_o),
        .m_addr_o(m_addr_o), .m_data_wr_o(m_data_wr_o), .m_rd_o(m_rd_o), .m_wr_o(m_wr_o),
        .m_cacheable_o(m_cacheable_o), .m_req_tag_o(m_req_tag_o), .m_invalidate_o(m_invalidate_o),
        .m_writeback_o(m_writeback_o), .m_flush_o(m_flush_o),
        .m_accept_i(m_accept_i), .m_ack_i(m_ack_i), .m_error_i(m_error_i),
        .m_data_rd_i(m_data_rd_i), .m_resp_tag_i(m_resp_tag_i),
        .spurious_o(spurious_o)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        {p0_addr_i, p0_data_wr_i, p0_rd_i, p0_wr_i, p0_cacheable_i, p0_req_tag_i} = '0;
        {p0_invalidate_i, p0_writeback_i, p0_flush_i} = '0;
        {p1_addr_i, p1_data_wr_i, p1_rd_i, p1_wr_i, p1_req_tag_i} = '0;
        {m_accept_i, m_ack_i, m_error_i, m_data_rd_i, m_resp_tag_i} = '0;
    endtask

    // Called just after a falling edge with inputs set: predict, check, advance model.
    task automatic applyStimulus();
        bit a0, a1, full, ok, acc;
        int g, owner;
        logic [REQ_W-1:0] exp_req, act_req;
        resp_t r;
        #1;
        a0 = p0_rd_i | (|p0_wr_i) | p0_invalidate_i | p0_writeback_i | p0_flush_i;
        a1 = p1_rd_i | (|p1_wr_i);
        full = (own_q.size() == OUTSTANDING);
        if (held_m == 0 && a0)      g = 0;
        else if (held_m == 1 && a1) g = 1;
        else if (a0 && a1)          g = 1 - last_m;
        else if (a0)                g = 0;
        else if (a1)                g = 1;
        else                        g = -1;
        acc = (g >= 0) && m_accept_i && !full && !rst_i;
        ok  = !full && !rst_i;
        checkOutput("p0_accept", p0_accept_o, acc && g == 0);
        checkOutput("p1_accept", p1_accept_o, acc && g == 1);
        checkOutput("spurious", spurious_o, spur_m);
        act_req = {m_addr_o, m_data_wr_o, m_rd_o, m_wr_o, m_cacheable_o, m_req_tag_o,
                   m_invalidate_o, m_writeback_o, m_flush_o};
        if (g == 0)
            exp_req = {p0_addr_i, p0_data_wr_i, p0_rd_i & ok, p0_wr_i & {4{ok}}, p0_cacheable_i,
                       p0_req_tag_i, p0_invalidate_i, p0_writeback_i, p0_flush_i};
        else if (g == 1)
            exp_req = {p1_addr_i, p1_data_wr_i, p1_rd_i & ok, p1_wr_i & {4{ok}}, 1'b0,
                       p1_req_tag_i, 3'b000};
        else
            exp_req = '0;
        if (rst_i) checkOutput("m_rdwr_reset", {m_rd_o, m_wr_o}, 5'b0);
        else       checkOutput("m_request", act_req, exp_req);
        if (m_ack_i && !rst_i && own_q.size() > 0) begin
            owner  = own_q[0];
            r.ack  = (owner == 0) ? 2'b01 : 2'b10;
            r.err  = m_error_i ? r.ack : 2'b00;
            r.data = m_data_rd_i;
            r.tag  = m_resp_tag_i;
            sb_q.push_back(r);
        end
        if (rst_i) begin
            own_q.delete();
            last_m = 1; held_m = -1; spur_m = 1'b0; acc_port = -1;
        end else begin
            if (m_ack_i) begin
                if (own_q.size() > 0) void'(own_q.pop_front());
                else spur_m = 1'b1;
            end
            if (acc) begin
                own_q.push_back(g);
                last_m = g;
                held_m = -1;
            end else begin
                held_m = g;
            end
            acc_port = acc ? g : -1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        idleInputs();
        for (int k = 0; k < OUTSTANDING + 2 && own_q.size() > 0; k++) begin
            m_ack_i = 1'b1;
            m_data_rd_i = $urandom;
            m_resp_tag_i = TAG_W'($urandom);
            applyStimulus();
        end
        idleInputs();
    endtask

    task automatic resetCycle();
        idleInputs();
        rst_i = 1'b1;
        applyStimulus();
        rst_i = 1'b0;
    endtask

    // Random masters hold a request until accepted and occasionally abandon it.
    task automatic randomStep();
        int k;
        if (acc_port == 0) pend0 = 1'b0;
        if (acc_port == 1) pend1 = 1'b0;
        if (pend0 && $urandom_range(15) == 0) pend0 = 1'b0;
        if (pend1 && $urandom_range(15) == 0) pend1 = 1'b0;
        if (!pend0) begin
            {p0_rd_i, p0_wr_i, p0_cacheable_i, p0_invalidate_i, p0_writeback_i, p0_flush_i} = '0;
            if ($urandom_range(2) == 0) begin
                pend0 = 1'b1;
                k = $urandom_range(9);
                p0_addr_i = $urandom; p0_data_wr_i = $urandom; p0_req_tag_i = TAG_W'($urandom);
                p0_cacheable_i = $urandom_range(1);
                if (k < 5)       p0_rd_i = 1'b1;
                else if (k < 8)  p0_wr_i = 4'($urandom_range(1, 15));
                else if (k == 8) p0_invalidate_i = 1'b1;
                else begin
                    p0_writeback_i = $urandom_range(1);
                    p0_flush_i = ~p0_writeback_i;
                end
            end
        end
        if (!pend1) begin
            {p1_rd_i, p1_wr_i} = '0;
            if ($urandom_range(2) == 0) begin
                pend1 = 1'b1;
                p1_addr_i = $urandom; p1_data_wr_i = $urandom; p1_req_tag_i = TAG_W'($urandom);
                if ($urandom_range(1) == 0) p1_rd_i = 1'b1;
                else p1_wr_i = 4'($urandom_range(1, 15));
            end
        end
        m_accept_i   = ($urandom_range(3) != 0);
        m_ack_i      = ($urandom_range(2) == 0);
        m_error_i    = ($urandom_range(7) == 0);
        m_data_rd_i  = $urandom;
        m_resp_tag_i = TAG_W'($urandom);
        rst_i        = ($urandom_range(499) == 0);
        applyStimulus();
    endtask

    // Monitor: every presented response must match the oldest expected one.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (p0_ack_o || p1_ack_o || sb_q.size() > 0) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_ack", {p1_ack_o, p0_ack_o}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("resp_ack", {p1_ack_o, p0_ack_o}, e.ack);
                    checkOutput("resp_err", {p1_error_o, p0_error_o}, e.err);
                    checkOutput("resp_data", {p1_data_rd_o, p0_data_rd_o}, {e.data, e.data});
                    checkOutput("resp_tag", {p1_resp_tag_o, p0_resp_tag_o}, {e.tag, e.tag});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();
        rst_i = 1'b1;
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        rst_i = 1'b0;

        // Ack with nothing in flight sets the sticky flag.
        m_ack_i = 1'b1; m_data_rd_i = 32'h1234_5678;
        applyStimulus();
        idleInputs();
        applyStimulus();
        applyStimulus();

        // Single port 0 read, acknowledged the next cycle.
        resetCycle();
        p0_rd_i = 1'b1; p0_addr_i = 32'h8000_0000; p0_req_tag_i = 11'h005; m_accept_i = 1'b1;
        applyStimulus();
        idleInputs();
        m_ack_i = 1'b1; m_data_rd_i = 32'hAAAA_AAAA; m_resp_tag_i = 11'h005;
        applyStimulus();
        idleInputs();
        applyStimulus();

        // Both ports reading continuously alternate, starting with port 0.
        resetCycle();
        for (int i = 0; i < 8; i++) begin
            p0_rd_i = 1'b1; p0_addr_i = 32'h100 + 32'(i);
            p1_rd_i = 1'b1; p1_addr_i = 32'h200 + 32'(i);
            m_accept_i = 1'b1;
            m_ack_i = (i > 0); m_data_rd_i = $urandom; m_resp_tag_i = TAG_W'(i);
            applyStimulus();
        end
        drain();

        // Port 1 write stalled for three cycles keeps its grant against port 0.
        resetCycle();
        p1_wr_i = 4'hF; p1_addr_i = 32'h4000; p1_data_wr_i = 32'hDEAD_BEEF;
        applyStimulus();
        p0_rd_i = 1'b1; p0_addr_i = 32'h5000;
        applyStimulus();
        applyStimulus();
        m_accept_i = 1'b1;
        applyStimulus();
        p1_wr_i = 4'h0;
        applyStimulus();
        drain();

        // Fill the owner FIFO, then ack and request in the same cycle.
        resetCycle();
        for (int i = 0; i < OUTSTANDING + 1; i++) begin
            p0_rd_i = 1'b1; p0_addr_i = 32'h600 + 32'(i); m_accept_i = 1'b1;
            applyStimulus();
        end
        m_ack_i = 1'b1; m_data_rd_i = 32'h0BAD_F00D;
        applyStimulus();
        m_ack_i = 1'b0;
        applyStimulus();
        drain();

        // Reset with two requests in flight; later acks are spurious.
        resetCycle();
        p0_rd_i = 1'b1; m_accept_i = 1'b1;
        applyStimulus();
        applyStimulus();
        resetCycle();
        m_ack_i = 1'b1;
        applyStimulus();
        applyStimulus();
        idleInputs();
        p0_rd_i = 1'b1; p1_rd_i = 1'b1; m_accept_i = 1'b1;
        applyStimulus();
        drain();

        // Randomized traffic.
        resetCycle();
        pend0 = 1'b0; pend1 = 1'b0;
        for (int i = 0; i < 3000; i++) randomStep();
        rst_i = 1'b0;
        drain();
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
